// File: rtl/mac_accumulator_pkg.sv
// Shared constants, FSM state type and saturation helper for the MAC accumulate stage.
// The helper is only used when SATURATE_EN is defined.
package mac_accumulator_pkg;

  localparam int IN_W_DEF  = 64;
  localparam int ACC_W_DEF = 80;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_e;

  // top2 = {true sign, result sign} of the one-bit-wider sum
  function automatic sat_e sat_dir(input logic [1:0] top2);
    case (top2)
      2'b01:   return SAT_POS;
      2'b10:   return SAT_NEG;
      default: return SAT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mac_add_sat.sv
// Combinational sign-extend / add / overflow detect, with clamping when SATURATE_EN
// is defined and modulo-2^ACC_W wrap otherwise.
module mac_add_sat
  import mac_accumulator_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  prod,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] wide;
  logic           raw_ovf;

  assign wide    = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - IN_W){prod[IN_W-1]}}, prod};
  assign raw_ovf = wide[ACC_W] ^ wide[ACC_W-1];

`ifdef SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

  always_comb begin
    unique case (sat_dir(wide[ACC_W -: 2]))
      SAT_POS: sum = ACC_MAX;
      SAT_NEG: sum = ACC_MIN;
      default: sum = wide[ACC_W-1:0];
    endcase
  end
  assign ovf = raw_ovf;
`else
  assign sum = wide[ACC_W-1:0];
  assign ovf = 1'b0;
`endif

  // Without overflow the truncated result must equal the exact wide sum.
  always_comb begin
    if (!raw_ovf) assert ($signed(sum) == $signed(wide));
  end

endmodule

// File: rtl/mac_accumulator.sv
// Signed product accumulator: sums beats until in_last, then holds the result on a
// registered output handshake. Overflow clamping/flag enabled by SATURATE_EN.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             in_xfer;
  logic             out_xfer;

  mac_add_sat #(
    .IN_W (IN_W),
    .ACC_W(ACC_W)
  ) u_add (
    .acc (acc_q),
    .prod(in_prod),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // NOTE: assign every always_comb output a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:     if (in_xfer && in_last) state_d = OUT;
      OUT:     if (out_xfer) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset here is synchronous and beats a
  // same-cycle transfer because it is tested first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_xfer) begin
        acc_q <= add_sum;
        cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        ovf_q <= ovf_q | add_ovf;
      end else if (out_xfer) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

  // The running registers are frozen in OUT, so they double as the output registers.
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

  a_excl: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));
  a_hold: assert property (@(posedge clk) disable iff (rst)
                           (out_valid && !out_ready) |=> $stable(out_sum));

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: default 80-bit instance via a scoreboard,
// plus a 64-bit / 3-bit-count instance for overflow and count saturation (SATURATE_EN aware).
module tb_mac_accumulator;

`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [63:0] in_prod;
  logic        in_ready, out_valid, out_ovf;
  logic [79:0] out_sum;
  logic [15:0] out_count;

  logic        b_valid, b_last, b_out_ready;
  logic [63:0] b_prod;
  logic        b_ready, b_out_valid, b_out_ovf;
  logic [63:0] b_out_sum;
  logic [2:0]  b_out_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  mac_accumulator #(.IN_W(64), .ACC_W(64), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_valid), .in_ready(b_ready), .in_prod(b_prod), .in_last(b_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  typedef struct {
    logic [79:0] sum;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [63:0] prod;
    bit          last;
    logic [79:0] exp_sum;
    logic [15:0] exp_cnt;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [63:0] p, input bit l,
                                  input logic [79:0] s, input logic [15:0] c);
    vec_t v;
    v.prod = p; v.last = l; v.exp_sum = s; v.exp_cnt = c;
    tbl.push_back(v);
  endfunction

  function automatic void push_exp(input logic [79:0] s, input logic [15:0] c);
    exp_t e;
    e.sum = s; e.cnt = c; e.ovf = 1'b0;
    exp_q.push_back(e);
  endfunction

  // Scoreboard: compare whenever the result handshake is about to happen.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result: got sum %h, expected no result", out_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_sum", out_sum, e.sum);
        check("sb_count", out_count, e.cnt);
        check("sb_ovf", out_ovf, e.ovf);
      end
    end
  end

  // Called just after a posedge; returns just after the edge that took the beat.
  task automatic send_beat(input logic [63:0] p, input bit l);
    int budget = 0;
    in_valid = 1'b1; in_prod = p; in_last = l;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got in_ready 0, expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic b_beat(input logic [63:0] p, input bit l);
    b_valid = 1'b1; b_prod = p; b_last = l;
    @(negedge clk);
    check("b_in_ready", b_ready, 1'b1);
    @(posedge clk); #1;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic b_result(input string name, input logic [63:0] s, input logic o,
                          input logic [2:0] c);
    check({name, "_valid"}, b_out_valid, 1'b1);
    check({name, "_sum"}, b_out_sum, s);
    check({name, "_ovf"}, b_out_ovf, o);
    check({name, "_count"}, b_out_count, c);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b1;
    b_valid = 1'b0; b_last = 1'b0; b_prod = '0; b_out_ready = 1'b1;

    add_vec(64'd3, 1'b0, '0, '0);
    add_vec(64'hFFFF_FFFF_FFFF_FFFB, 1'b0, '0, '0);
    add_vec(64'd10, 1'b1, 80'd8, 16'd3);
    add_vec(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, {80{1'b1}}, 16'd1);
    add_vec(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, '0, '0);
    add_vec(64'd1, 1'b1, 80'h0_8000_0000_0000_0000, 16'd2);
    add_vec(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, '0);
    add_vec(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 80'hFFFF_FFFF_FFFF_FFFF_FFFE, 16'd2);
    add_vec(64'h8000_0000_0000_0000, 1'b0, '0, '0);
    add_vec(64'h8000_0000_0000_0000, 1'b1, 80'hFFFF_0000_0000_0000_0000, 16'd2);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, '0);
    check("rst_out_count", out_count, '0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_b_in_ready", b_ready, 1'b1);
    @(posedge clk); #1;

    // Back-to-back table vectors; each result drains the cycle after its last beat.
    foreach (tbl[i]) begin
      if (tbl[i].last) push_exp(tbl[i].exp_sum, tbl[i].exp_cnt);
      send_beat(tbl[i].prod, tbl[i].last);
      if (tbl[i].last) begin
        check("latency_out_valid", out_valid, 1'b1);
        check("latency_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        check("post_hs_in_ready", in_ready, 1'b1);
        check("post_hs_out_sum_clr", out_sum, '0);
      end
    end

    // Back-pressure: result must hold and the new beat must wait for the handshake.
    out_ready = 1'b0;
    push_exp(80'd5, 16'd1);
    send_beat(64'd5, 1'b1);
    push_exp(80'd9, 16'd1);
    in_valid = 1'b1; in_prod = 64'd9; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_sum", out_sum, 80'd5);
      check("hold_count", out_count, 16'd1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_out_valid", out_valid, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    check("no_bypass_in_ready", in_ready, 1'b0);
    send_beat(64'd9, 1'b1);
    @(posedge clk); #1;

    // Reset mid-vector, with a same-cycle last beat that reset must override.
    send_beat(64'd100, 1'b0);
    send_beat(64'd200, 1'b0);
    in_valid = 1'b1; in_prod = 64'd50; in_last = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_sum", out_sum, '0);
    check("midrst_count", out_count, '0);
    push_exp(80'd7, 16'd1);
    send_beat(64'd7, 1'b1);
    @(posedge clk); #1;

    // 64-bit accumulator: overflow behaviour, sticky clear, count saturation.
    b_beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    b_beat(64'd1, 1'b1);
    b_result("pos_ovf", SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000, SAT, 3'd2);

    b_beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    b_beat(64'd1, 1'b0);
    b_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    b_result("after_clamp", SAT ? 64'h7FFF_FFFF_FFFF_FFFE : 64'h7FFF_FFFF_FFFF_FFFF, SAT, 3'd3);

    b_beat(64'h8000_0000_0000_0000, 1'b0);
    b_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    b_result("neg_ovf", SAT ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF, SAT, 3'd2);

    b_beat(64'd5, 1'b1);
    b_result("ovf_cleared", 64'd5, 1'b0, 3'd1);

    for (int k = 0; k < 9; k++) b_beat(64'd1, k == 8);
    b_result("cnt_sat", 64'd9, 1'b0, 3'd7);

    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      budget++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
